run_detector: RTL and testbench
===============================

// Module: run_detector
// PURPOSE
//  Parametrised Moore run-length detector; successor to the fixed 3-bit w/z sequence FSM.
//  Samples serial input w on enabled cycles and asserts z once RUN_LEN consecutive qualifying
//  samples are seen. Four run modes; saturating detection counter.
//  Sits between a synchronised input (switch/button) and status LEDs or a downstream counter.
// PARAMETERS
//  RUN_LEN  4  qualifying samples needed to assert z; legal range >= 2
//  HIT_W    8  width of hit_count
//  CNT_W    localparam = $clog2(RUN_LEN+1); width of run_count
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  en         in   1      sample enable; w is ignored and all state held when 0
//  w          in   1      serial data input
//  mode       in   2      00 equal-run (either value), 01 ones, 10 zeros, 11 alternating
//  clr_hits   in   1      synchronous clear of hit_count
//  z          out  1      detect flag; 1 iff state==DETECT (Moore, registered)
//  state      out  2      00 IDLE, 01 TRACK, 10 DETECT; 11 never produced
//  run_count  out  CNT_W  current qualifying run length, saturates at RUN_LEN
//  last_w     out  1      last accepted sample
//  hit_count  out  HIT_W  TRACK/IDLE->DETECT transitions, saturating at 2^HIT_W-1
// BEHAVIOUR
//  - Reset (sync, takes priority over all else): state=IDLE, run_count=0, last_w=0, z=0,
//    hit_count=0, mode_q=00.
//  - mode registered as mode_q every cycle, regardless of en. If mode!=mode_q at an edge:
//    next state=IDLE, run_count=0, z=0. The w sample at that edge is discarded.
//  - en=0 and no mode change: all registers hold; hit_count still honours clr_hits.
//  - Accepted sample (en=1, no mode change): last_w<=w. Next run r' is computed from r:
//      from IDLE: 00/11 -> 1; 01 -> w?1:0; 10 -> w?0:1
//      00: w==last_w ? sat(r+1) : 1          11: w!=last_w ? sat(r+1) : 1
//      01: w ? sat(r+1) : 0                  10: !w ? sat(r+1) : 0
//    sat(x) = min(x, RUN_LEN).
//  - Next state from r': r'==RUN_LEN -> DETECT; else r'>0 -> TRACK; else IDLE.
//    Transitions allowed: IDLE->TRACK/DETECT, TRACK->any, DETECT->any.
//  - Latency: z rises on the same edge that accepts the RUN_LEN-th qualifying sample.
//    z falls on the edge accepting the first non-qualifying sample.
//    z stays 1 while qualifying samples continue; run_count stays at RUN_LEN.
//  - hit_count: +1 (saturating) when state enters DETECT from non-DETECT.
//    clr_hits=1 forces 0 and wins over a simultaneous increment.
//  - Reset or mode change mid-run discards the partial run; there is no memory of prior samples.
// TESTING (RUN_LEN=4, HIT_W=8 unless noted)
//  1. mode00, en=1, w=1,1,1,1 -> z=0 after edges 1-3; z=1, state=10, hit=1 after edge 4.
//     Then w=1 -> z=1, hit=1. Then w=0 -> z=0, run=1, state=01.
//  2. mode01, w=0 x6 -> run=0, state=00, z=0. Then w=1 x4 -> z=1 after 4th; mode10 mirror case.
//  3. mode11, w=0,1,0,1 -> z=1 after 4th edge. Then w=1 -> run=1, z=0, state=01.
//  4. mode00, w=1,1, then en=0 x3 with w=0, then en=1 w=1,1 -> z=1 at 2nd re-enabled edge;
//     registers unchanged during en=0.
//  5. run=3 in mode00, then reset=1 one cycle -> all outputs 0 next edge.
//     Repeat with mode->01 instead of reset -> state=IDLE, run=0; w at that edge ignored.
//  6. HIT_W=2: 4 detections -> hit=3 (saturated). clr_hits coincident with DETECT entry -> hit=0.

Source files
------------

// File: rtl/run_detector.sv
// run_detector: Moore run-length detector.
// Watches the serial input w on enabled cycles and raises z once RUN_LEN
// consecutive qualifying samples have been accepted. There are four run modes:
// equal values, ones, zeros and alternating. A saturating counter records
// how many times the detector has entered DETECT.
module run_detector #(
  parameter  int RUN_LEN = 4,
  parameter  int HIT_W   = 8,
  localparam int CNT_W   = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             w,
  input  logic [1:0]       mode,
  input  logic             clr_hits,
  output logic             z,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] run_count,
  output logic             last_w,
  output logic [HIT_W-1:0] hit_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    TRACK  = 2'b01,
    DETECT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);
  localparam logic [HIT_W-1:0] HIT_MAX = '1;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] run_inc;
  logic [CNT_W-1:0] run_d;
  logic             mode_changed;
  logic             enter_detect;

  assign state        = state_q;
  assign mode_changed = (mode != mode_q);

  // The DETECT entry only counts when a sample is accepted. The mode must be
  // unchanged and en must be high.
  assign enter_detect = en && !mode_changed && (state_d == DETECT) && (state_q != DETECT);

  // Next run length and next state for a sample accepted at this edge.
  // The run is extended by one, saturating at RUN_LEN. If the sample breaks the
  // run, the run restarts. In modes 00 and 11, leaving IDLE always starts a
  // run of 1 because any first sample qualifies.
  always_comb begin
    run_inc = (run_count >= RUN_MAX) ? RUN_MAX : run_count + RUN_ONE;
    run_d   = '0;
    state_d = IDLE;
    case (mode)
      2'b00: begin
        if (state_q == IDLE)  run_d = RUN_ONE;
        else if (w == last_w) run_d = run_inc;
        else                  run_d = RUN_ONE;
      end
      2'b01: begin
        run_d = w ? run_inc : '0;
      end
      2'b10: begin
        run_d = !w ? run_inc : '0;
      end
      default: begin
        if (state_q == IDLE)  run_d = RUN_ONE;
        else if (w != last_w) run_d = run_inc;
        else                  run_d = RUN_ONE;
      end
    endcase
    if (run_d == RUN_MAX)  state_d = DETECT;
    else if (run_d != '0)  state_d = TRACK;
    else                   state_d = IDLE;
  end

  // Main state registers.
  // A mode change throws away the partial run and the sample taken at that
  // edge. en=0 freezes everything except the hit counter clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      run_count <= '0;
      last_w    <= 1'b0;
      z         <= 1'b0;
      mode_q    <= 2'b00;
    end else begin
      mode_q <= mode;
      if (mode_changed) begin
        state_q   <= IDLE;
        run_count <= '0;
        z         <= 1'b0;
      end else if (en) begin
        last_w    <= w;
        run_count <= run_d;
        state_q   <= state_d;
        z         <= (state_d == DETECT);
      end
    end
  end

  // Saturating count of DETECT entries. A clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count <= '0;
    end else if (clr_hits) begin
      hit_count <= '0;
    end else if (enter_detect && (hit_count != HIT_MAX)) begin
      hit_count <= hit_count + HIT_W'(1);
    end
  end

endmodule

// File: tb/tb_run_detector.sv
// tb_run_detector: directed-vector bench for run_detector.
// Expected values are worked out by hand from the detector's behaviour.
// A second instance with a 2-bit hit counter shares the same stimulus and
// exercises saturation of the hit counter.
module tb_run_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       w = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       clr_hits = 1'b0;

  logic       z;
  logic [1:0] state;
  logic [2:0] run_count;
  logic       last_w;
  logic [7:0] hit_count;

  logic       z2;
  logic [1:0] state2;
  logic [2:0] run_count2;
  logic       last_w2;
  logic [1:0] hit_count2;

  int vectorCount = 0;
  int missCount   = 0;

  run_detector #(.RUN_LEN(4), .HIT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .clr_hits(clr_hits),
    .z(z), .state(state), .run_count(run_count), .last_w(last_w), .hit_count(hit_count)
  );

  run_detector #(.RUN_LEN(4), .HIT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .clr_hits(clr_hits),
    .z(z2), .state(state2), .run_count(run_count2), .last_w(last_w2), .hit_count(hit_count2)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Drive one cycle of inputs away from the rising edge, then let the edge
  // happen. Outputs are left settled just after that edge.
  task automatic applyStimulus(input logic r, input logic e, input logic wv,
                               input logic [1:0] m, input logic c);
    @(negedge clk);
    reset    = r;
    en       = e;
    w        = wv;
    mode     = m;
    clr_hits = c;
    @(posedge clk);
    #1;
  endtask

  // Apply n identical accepted samples.
  task automatic applyRepeat(input int n, input logic wv, input logic [1:0] m);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, wv, m, 1'b0);
  endtask

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectorCount++;
    if (observed != expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("rst_z", z, 0);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_run", run_count, 0);
    checkOutput("rst_lastw", last_w, 0);
    checkOutput("rst_hit", hit_count, 0);

    // 1: equal-run mode, four ones
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
      checkOutput("t1_z_early", z, 0);
      checkOutput("t1_run_early", run_count, i);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
    checkOutput("t1_z_det", z, 1);
    checkOutput("t1_state_det", state, 2);
    checkOutput("t1_hit_det", hit_count, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
    checkOutput("t1_z_hold", z, 1);
    checkOutput("t1_run_sat", run_count, 4);
    checkOutput("t1_hit_hold", hit_count, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    checkOutput("t1_z_break", z, 0);
    checkOutput("t1_run_break", run_count, 1);
    checkOutput("t1_state_break", state, 1);

    // 2: ones mode, zeros never qualify; the first edge is a mode change
    applyRepeat(6, 1'b0, 2'b01);
    checkOutput("t2_run_zeros", run_count, 0);
    checkOutput("t2_state_zeros", state, 0);
    checkOutput("t2_z_zeros", z, 0);
    applyRepeat(3, 1'b1, 2'b01);
    checkOutput("t2_z_three", z, 0);
    applyRepeat(1, 1'b1, 2'b01);
    checkOutput("t2_z_ones", z, 1);
    checkOutput("t2_hit_ones", hit_count, 2);
    // zeros mode mirror: the mode-change edge plus one more one, both non-qualifying
    applyRepeat(2, 1'b1, 2'b10);
    checkOutput("t2_state_m10", state, 0);
    checkOutput("t2_run_m10", run_count, 0);
    applyRepeat(4, 1'b0, 2'b10);
    checkOutput("t2_z_zeros_det", z, 1);
    checkOutput("t2_hit_zeros", hit_count, 3);

    // 3: alternating mode, with the mode-change edge first
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
    checkOutput("t3_state_chg", state, 0);
    applyRepeat(1, 1'b0, 2'b11);
    applyRepeat(1, 1'b1, 2'b11);
    applyRepeat(1, 1'b0, 2'b11);
    checkOutput("t3_z_three", z, 0);
    applyRepeat(1, 1'b1, 2'b11);
    checkOutput("t3_z_alt", z, 1);
    checkOutput("t3_hit_alt", hit_count, 4);
    applyRepeat(1, 1'b1, 2'b11);
    checkOutput("t3_run_break", run_count, 1);
    checkOutput("t3_z_break", z, 0);
    checkOutput("t3_state_break", state, 1);

    // 4: enable gating; the mode-change edge discards its sample
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
    applyRepeat(2, 1'b1, 2'b00);
    checkOutput("t4_run_pre", run_count, 2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
      checkOutput("t4_run_hold", run_count, 2);
      checkOutput("t4_state_hold", state, 1);
      checkOutput("t4_lastw_hold", last_w, 1);
      checkOutput("t4_z_hold", z, 0);
    end
    applyRepeat(1, 1'b1, 2'b00);
    checkOutput("t4_z_re1", z, 0);
    applyRepeat(1, 1'b1, 2'b00);
    checkOutput("t4_z_re2", z, 1);
    checkOutput("t4_hit_re2", hit_count, 5);

    // 5: reset mid-run, then a mode change mid-run
    applyRepeat(3, 1'b0, 2'b00);
    checkOutput("t5_run3", run_count, 3);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
    checkOutput("t5_rst_z", z, 0);
    checkOutput("t5_rst_state", state, 0);
    checkOutput("t5_rst_run", run_count, 0);
    checkOutput("t5_rst_lastw", last_w, 0);
    checkOutput("t5_rst_hit", hit_count, 0);
    applyRepeat(3, 1'b1, 2'b00);
    checkOutput("t5_run3b", run_count, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    checkOutput("t5_chg_state", state, 0);
    checkOutput("t5_chg_run", run_count, 0);
    checkOutput("t5_chg_z", z, 0);
    checkOutput("t5_chg_lastw", last_w, 1);
    applyRepeat(1, 1'b1, 2'b01);
    checkOutput("t5_after_run", run_count, 1);

    // 6: hit counter saturation on the 2-bit instance, then clear versus entry
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    applyRepeat(4, 1'b1, 2'b00);
    checkOutput("t6_hit2_d1", hit_count2, 1);
    applyRepeat(4, 1'b0, 2'b00);
    checkOutput("t6_hit2_d2", hit_count2, 2);
    applyRepeat(4, 1'b1, 2'b00);
    checkOutput("t6_hit2_d3", hit_count2, 3);
    applyRepeat(4, 1'b0, 2'b00);
    checkOutput("t6_hit2_sat", hit_count2, 3);
    checkOutput("t6_hit_wide", hit_count, 4);
    checkOutput("t6_z2_d4", z2, 1);
    applyRepeat(3, 1'b1, 2'b00);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 1'b1);
    checkOutput("t6_clr_z", z, 1);
    checkOutput("t6_clr_hit", hit_count, 0);
    checkOutput("t6_clr_hit2", hit_count2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
